// File: rtl/flash_audio_pkg.sv
// Shared constants for the flash audio path: sample width, default buffer depth,
// the silence word and the unsigned-8-bit conversion helper.
package flash_audio_pkg;

  localparam int unsigned SAMPLE_W      = 16;
  localparam int unsigned DEFAULT_DEPTH = 16;

  localparam logic [SAMPLE_W-1:0] SILENCE      = 16'h0000;
  localparam logic [7:0]          U8_SIGN_FLIP = 8'h80;

  // Unsigned 8-bit PCM to signed 16-bit, left-justified.
  function automatic logic [SAMPLE_W-1:0] u8_to_s16(input logic [7:0] b);
    return {b ^ U8_SIGN_FLIP, 8'h00};
  endfunction

endpackage

// File: rtl/sample_sync_fifo.sv
// Single-clock sample FIFO with registered read data. Full and empty come from
// the occupancy count, so the pointers simply wrap modulo DEPTH.
module sample_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] rdata_q;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop) begin
        rptr_q  <= rptr_q + AW'(1);
        rdata_q <= mem[rptr_q];
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LW'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr_q] <= wdata;
  end

  assign rdata = rdata_q;
  assign level = level_q;

endmodule

// File: rtl/flash_sample_fifo.sv
// Packs the SPI reader's byte stream into PCM samples and buffers them for I2S.
// Define FLASH_U8_AUDIO_EN to treat each byte as one unsigned 8-bit sample.
module flash_sample_fifo #(
  parameter int unsigned DEPTH    = flash_audio_pkg::DEFAULT_DEPTH,
  parameter int unsigned SAMPLE_W = flash_audio_pkg::SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     pausa,
  input  logic                     flush,
  input  logic                     sample_req,
  output logic [SAMPLE_W-1:0]      sample_out,
  output logic                     sample_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underrun
);

  import flash_audio_pkg::*;

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic                push, pop;
  logic [SAMPLE_W-1:0] push_data;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic [LW-1:0]       fifo_level;
  logic                fifo_full, fifo_empty;
  logic                silence_q, valid_q, overflow_q, underrun_q;

`ifdef FLASH_U8_AUDIO_EN
  assign push      = byte_valid && !flush;
  assign push_data = u8_to_s16(byte_in);
`else
  logic       phase_q;
  logic [7:0] low_q;

  assign push      = byte_valid && !flush && phase_q;
  assign push_data = {byte_in, low_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      low_q   <= 8'h00;
    end else if (flush) begin
      phase_q <= 1'b0;
    end else if (byte_valid) begin
      phase_q <= ~phase_q;
      if (!phase_q) low_q <= byte_in;
    end
  end
`endif

  assign pop = sample_req && !flush;

  sample_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      silence_q  <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      valid_q <= pop;
      // An empty pop leaves the FIFO's read register alone; mask it to silence instead.
      if (pop) silence_q <= fifo_empty;
      if (flush) begin
        overflow_q <= 1'b0;
        underrun_q <= 1'b0;
      end else begin
        if (push && fifo_full && !pop) overflow_q <= 1'b1;
        if (pop && fifo_empty)         underrun_q <= 1'b1;
      end
    end
  end

  assign sample_out   = silence_q ? SILENCE : fifo_rdata;
  assign sample_valid = valid_q;
  assign level        = fifo_level;
  assign overflow     = overflow_q;
  assign underrun     = underrun_q;
  assign pausa        = (fifo_level >= LW'(DEPTH - 1));

endmodule
